// File: rtl/audio_sample_prep.sv
// Audio front end for the HDMI encoder: per-channel first-order IIR low-pass, fractional
// 48 kHz clock generator, and volume-scaled 16-bit stereo word held stable around clk_audio rises.
module audio_sample_prep #(
  parameter int SAMPLE_RATE  = 48000,
  parameter int FILTER_SHIFT = 4,
  parameter int FREQ_W       = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FREQ_W-1:0] clk_freq,
  input  logic [17:0]       audio_l,
  input  logic [17:0]       audio_r,
  input  logic [1:0]        system_volume,
  output logic              clk_audio,
  output logic              sample_stb,
  output logic [31:0]       sample_word
);

  localparam int DATA_W = 18;
  localparam int FW     = DATA_W + FILTER_SHIFT;
  localparam int ACC_W  = FREQ_W + 1;
  localparam int SUM_W  = FREQ_W + 2;
  localparam logic [SUM_W-1:0] PHASE_STEP = SUM_W'(2 * SAMPLE_RATE);

  // f + x - f/2^k; the true result always fits FW bits, so modular arithmetic is exact.
  function automatic logic signed [FW-1:0] iir_next(input logic signed [FW-1:0] f,
                                                    input logic signed [DATA_W-1:0] x);
    logic signed [FW-1:0] xe;
    xe = FW'(x);
    return f + xe - (f >>> FILTER_SHIFT);
  endfunction

  function automatic logic signed [15:0] apply_volume(input logic signed [15:0] s,
                                                      input logic [1:0] vol);
    logic signed [15:0] r;
    case (vol)
      2'd0:    r = '0;
      2'd1:    r = s >>> 2;
      2'd2:    r = s >>> 1;
      default: r = s;
    endcase
    return r;
  endfunction

  logic signed [DATA_W-1:0] xl_p0, xr_p0;
  logic signed [FW-1:0]     fl_p1, fr_p1;
  logic signed [DATA_W-1:0] yl_p1, yr_p1;
  logic signed [15:0]       sl_p1, sr_p1;
  logic                     unused_lsbs;

  logic [ACC_W-1:0] acc, acc_next;
  logic [SUM_W-1:0] acc_n, acc_sub, freq_ext;
  logic             toggle;

  assign yl_p1 = fl_p1[FW-1 -: DATA_W];
  assign yr_p1 = fr_p1[FW-1 -: DATA_W];
  assign sl_p1 = yl_p1[17:2];
  assign sr_p1 = yr_p1[17:2];
  assign unused_lsbs = ^{yl_p1[1:0], yr_p1[1:0]};

  // Below 2*SAMPLE_RATE the remainder can exceed clk_freq; clamping keeps a toggle every cycle.
  always_comb begin
    freq_ext = {2'b00, clk_freq};
    acc_n    = {1'b0, acc} + PHASE_STEP;
    acc_sub  = acc_n - freq_ext;
    toggle   = 1'b0;
    acc_next = acc;
    if (clk_freq != '0) begin
      if (acc_n >= freq_ext) begin
        toggle   = 1'b1;
        acc_next = (acc_sub >= freq_ext) ? '0 : acc_sub[ACC_W-1:0];
      end else begin
        acc_next = acc_n[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xl_p0       <= '0;
      xr_p0       <= '0;
      fl_p1       <= '0;
      fr_p1       <= '0;
      acc         <= '0;
      clk_audio   <= 1'b0;
      sample_stb  <= 1'b0;
      sample_word <= '0;
    end else begin
      // p0: input register
      xl_p0 <= audio_l;
      xr_p0 <= audio_r;
      // p1: filter state
      fl_p1 <= iir_next(fl_p1, xl_p0);
      fr_p1 <= iir_next(fr_p1, xr_p0);
      // output: capture only on the falling edge of clk_audio
      acc        <= acc_next;
      clk_audio  <= clk_audio ^ toggle;
      sample_stb <= toggle & clk_audio;
      if (toggle && clk_audio)
        sample_word <= {apply_volume(sl_p1, system_volume), apply_volume(sr_p1, system_volume)};
    end
  end

endmodule

// File: tb/tb_audio_sample_prep.sv
// Directed bench for audio_sample_prep: clock generator timing, bypass latency, volume,
// reset/freeze behaviour and the IIR step response (FILTER_SHIFT 0 and 4 instances).
module tb_audio_sample_prep;

  logic        clk;
  logic        reset;
  logic [26:0] clk_freq;
  logic [17:0] audio_l, audio_r;
  logic [1:0]  system_volume;
  logic        ca0, stb0, ca4, stb4;
  logic [31:0] w0, w4;

  int      errors, checks;
  longint  k, fm;
  longint  last_tog;
  int      tog_cnt;
  logic    prev_ca;
  logic    chk_spacing;
  logic [15:0] prev_left, left;

  audio_sample_prep #(.FILTER_SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .clk_freq(clk_freq), .audio_l(audio_l), .audio_r(audio_r),
    .system_volume(system_volume), .clk_audio(ca0), .sample_stb(stb0), .sample_word(w0));

  audio_sample_prep #(.FILTER_SHIFT(4)) dut4 (
    .clk(clk), .reset(reset), .clk_freq(clk_freq), .audio_l(audio_l), .audio_r(audio_r),
    .system_volume(system_volume), .clk_audio(ca4), .sample_stb(stb4), .sample_word(w4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Toggles completed after kk edges since reset release with a constant clk_freq.
  function automatic longint n_of(input longint kk);
    if (fm < 96000) return kk;
    return (kk * 96000) / fm;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk();
    longint n0, n1;
    longint sp;
    tick();
    k++;
    n0 = n_of(k - 1);
    n1 = n_of(k);
    chk("clk_audio", 32'(ca0), 32'(n1[0]));
    chk("clk_audio_f4", 32'(ca4), 32'(n1[0]));
    chk("sample_stb", 32'(stb0), 32'((n1 != n0) && !n1[0]));
    chk("sample_stb_f4", 32'(stb4), 32'((n1 != n0) && !n1[0]));
    if (ca0 !== prev_ca) begin
      tog_cnt++;
      sp = k - last_tog;
      if (chk_spacing) chk("toggle_spacing", 32'((sp == 10) || (sp == 11)), 32'd1);
      last_tog = k;
    end
    prev_ca = ca0;
  endtask

  task automatic run_to(input longint t);
    while (k < t) step_chk();
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; clk_freq = 27'd960000;
    audio_l = '0; audio_r = '0; system_volume = 2'd3;
    errors = 0; checks = 0; fm = 960000; k = 0;
    tog_cnt = 0; last_tog = 0; prev_ca = 1'b0; chk_spacing = 1'b0;
    repeat (3) tick();
    chk("reset_clk_audio", 32'(ca0), 32'd0);
    chk("reset_stb", 32'(stb0), 32'd0);
    chk("reset_word", w0, 32'd0);
    chk("reset_word_f4", w4, 32'd0);

    // integer ratio, bypass and latency
    reset = 1'b0; k = 0;
    audio_l = 18'h1FFFC; audio_r = 18'h20000;
    run_to(10);
    chk("first_toggle_960k", 32'(ca0), 32'd1);
    run_to(20);
    chk("bypass_word", w0, 32'h7FFF8000);
    run_to(30);
    chk("bypass_hold", w0, 32'h7FFF8000);
    run_to(37);
    audio_l = 18'h00400; audio_r = 18'h00000;
    run_to(38);
    audio_l = 18'h00800;
    run_to(40);
    chk("latency_2_cycles", w0, 32'h01000000);
    run_to(60);
    chk("latency_next", w0, 32'h02000000);

    // volume
    audio_l = 18'h10000; audio_r = 18'h30000; system_volume = 2'd0;
    run_to(80);
    chk("vol0", w0, 32'h00000000);
    system_volume = 2'd1;
    run_to(100);
    chk("vol1", w0, 32'h1000F000);
    system_volume = 2'd2;
    run_to(120);
    chk("vol2", w0, 32'h2000E000);
    system_volume = 2'd3;
    run_to(140);
    chk("vol3", w0, 32'h4000C000);
    run_to(150);
    system_volume = 2'd1;
    run_to(155);
    chk("vol_change_held", w0, 32'h4000C000);
    run_to(160);
    chk("vol_change_next", w0, 32'h1000F000);

    // reset while clk_audio is high
    run_to(175);
    chk("clk_audio_high_pre_reset", 32'(ca0), 32'd1);
    reset = 1'b1;
    tick();
    chk("midreset_clk_audio", 32'(ca0), 32'd0);
    chk("midreset_stb", 32'(stb0), 32'd0);
    chk("midreset_word", w0, 32'd0);
    clk_freq = 27'd1000000; fm = 1000000;
    tick(); tick();
    reset = 1'b0; k = 0; prev_ca = 1'b0;
    tog_cnt = 0; last_tog = 0; chk_spacing = 1'b1;

    // fractional ratio 1 MHz / 96 kHz
    run_to(10);
    chk("frac_no_toggle_10", 32'(ca0), 32'd0);
    run_to(11);
    chk("frac_first_toggle_11", 32'(ca0), 32'd1);
    run_to(2500);
    chk_spacing = 1'b0;
    chk("frac_toggle_count", 32'(tog_cnt), 32'd240);
    run_to(2511);
    chk("pre_freeze_high", 32'(ca0), 32'd1);

    // freeze
    clk_freq = '0;
    repeat (1000) begin
      tick();
      chk("freeze_clk_audio", 32'(ca0), 32'd1);
      chk("freeze_stb", 32'(stb0), 32'd0);
    end
    clk_freq = 27'd1000000;
    run_to(2600);

    // filter step with toggles every cycle
    reset = 1'b1; clk_freq = 27'd50000; fm = 50000;
    audio_l = '0; audio_r = '0; system_volume = 2'd3;
    tick(); tick();
    reset = 1'b0; k = 0; prev_ca = 1'b0;
    audio_l = 18'h10000;
    prev_left = '0;
    while (k < 600) begin
      step_chk();
      if (stb4) begin
        left = w4[31:16];
        chk("filter_monotonic", 32'(left >= prev_left), 32'd1);
        prev_left = left;
        if (k == 2)  chk("filter_k2", w4, 32'h00000000);
        if (k == 4)  chk("filter_k4", w4, 32'h07C00000);
        if (k == 6)  chk("filter_k6", w4, 32'h0E8F0000);
        if (k == 18) chk("filter_63pct", 32'(left >= 16'd10322), 32'd1);
        if (k >= 560) chk("filter_final", w4, 32'h40000000);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_sample_prep.md
# audio_sample_prep

Audio front-end stage feeding the HDMI encoder's audio port. It takes the core's raw 18-bit signed stereo samples, which update at arbitrary times in the pixel-clock domain, and does four things:
- low-pass filters them with a first-order IIR;
- derives an exact-average 48 kHz `clk_audio` from the pixel clock using a fractional accumulator;
- applies the OSD volume setting;
- holds the 16-bit stereo sample word stable across every rising edge of `clk_audio`.

It replaces the free-running integer audio divider and the ad-hoc truncation/volume logic in the video top level.

## Interface

Parameters:
- `SAMPLE_RATE`, default 48000: output sample rate in Hz.
- `FILTER_SHIFT`, default 4: IIR coefficient exponent; 0 gives an exact bypass.
- `FREQ_W`, default 27: width of `clk_freq` and the phase accumulator.

Ports:
- `clk`  in  1: pixel clock; the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `clk_freq`  in  FREQ_W: pixel clock frequency in Hz (e.g. 31500000); quasi-static.
- `audio_l`  in  18: left sample, signed; sampled every `clk`.
- `audio_r`  in  18: right sample, signed.
- `system_volume`  in  2: 0 = mute, 1 = −12 dB, 2 = −6 dB, 3 = 0 dB.
- `clk_audio`  out  1: 50%-average-duty audio clock to the HDMI encoder.
- `sample_stb`  out  1: one-cycle pulse when `sample_word` updates.
- `sample_word`  out  32: `{left[15:0], right[15:0]}`, signed.

## Operation

**Input stage**
- `audio_l`/`audio_r` are registered once (`xl`, `xr`) before filtering.

**IIR filter (per channel)**
- State `f` is signed, 18+FILTER_SHIFT bits.
- Update every cycle: `f <= f + sext(x) − (f >>> FILTER_SHIFT)`.
- Filter output: `y = f >>> FILTER_SHIFT`, 18 bits.
- Steady state for constant x: `f = x << FILTER_SHIFT`, so `y = x`.
- With FILTER_SHIFT = 0: `y = x` one cycle after `x`.

**Phase accumulator**
- `acc` is unsigned, FREQ_W+1 bits.
- Each cycle: `acc_n = acc + 2·SAMPLE_RATE`.
- If `acc_n ≥ clk_freq`: `acc <= acc_n − clk_freq` and `clk_audio` toggles. Otherwise `acc <= acc_n`.
- At most one toggle per cycle. Average toggle rate is exactly 2·SAMPLE_RATE·(1/clk_freq) per cycle.
- `clk_freq == 0`: generator frozen. `acc` holds, `clk_audio` holds, no strobes.
- `clk_freq < 2·SAMPLE_RATE`: toggles every cycle. This is legal and outside the intended range.
- A change of `clk_freq` takes effect the next cycle with no reset of `acc`.

**Sample capture**
- Capture happens on the cycle in which `clk_audio` toggles 1→0, i.e. the registered `clk_audio` goes low.
- In that cycle, `sample_word` loads from the current `y` of each channel, converted and scaled as below, and `sample_stb` = 1.
- `sample_word` is therefore constant for a full half-period before and after each rising edge of `clk_audio`. This is the CDC guarantee the HDMI audio domain relies on.
- Conversion: `s16 = y[17:2]`, an arithmetic ÷4 with no saturation needed.
- Volume:
  - 0 → 0
  - 1 → `s16 >>> 2`
  - 2 → `s16 >>> 1`
  - 3 → `s16`
- Volume is sampled at capture only. A change mid-period appears at the next capture.

**Reset**
- Values while `reset` = 1 and on the first cycle after release: `xl`, `xr`, `f`, `acc`, `clk_audio`, `sample_stb`, `sample_word` all = 0.

## Timing

- Input to filter output: `audio_*` at cycle n → `xl` at n+1 → `f` updated at n+2.
- With FILTER_SHIFT = 0, a capture at cycle c uses the `audio_*` value present at cycle c−2.
- `clk_audio` toggles one cycle after the cycle in which `acc_n ≥ clk_freq` is evaluated, because it is a registered output.
- `sample_stb` and the `sample_word` update are coincident with the falling edge of `clk_audio`, in the same cycle.
- After reset release with `clk_freq = F`:
  - first toggle (0→1) at cycle ⌈F / (2·SAMPLE_RATE)⌉;
  - first capture on the second toggle.
- Reset asserted mid-period forces `clk_audio` low immediately on the next edge. No `sample_stb` is generated for that forced fall.
- All outputs are registered. There is no combinational path from input to output.

## Test plan

- **Integer ratio.** Setup: `clk_freq` = 960000, SAMPLE_RATE = 48000. Required: `clk_audio` toggles every 10 cycles exactly (period 20), and `sample_stb` occurs every 20 cycles, coincident with each fall.
- **Fractional ratio.** Setup: `clk_freq` = 1000000, run 1000000 cycles from reset. Required:
  - exactly 96000 `clk_audio` toggles;
  - toggle spacing only 10 or 11 cycles;
  - `acc` back to 0 at the end.
- **Bypass and latency.** Setup: FILTER_SHIFT = 0, volume = 3, `audio_l` = 18'h1FFFC, `audio_r` = 18'h20000. Required: next `sample_word` = {16'h7FFF, 16'h8000}. A step applied 2 cycles before a capture is reflected; a step applied 1 cycle before is not.
- **Filter step.** Setup: FILTER_SHIFT = 4, `audio_l` steps 0 → 18'h10000. Required:
  - `y` is monotonic non-decreasing;
  - `y` reaches 18'h10000 exactly and holds;
  - `y` reaches ≥ 63% of final by cycle 18 after the step.
- **Volume.** Setup: constant `s16` = 16'h4000; `system_volume` = 0, 1, 2, 3. Required: `sample_word` left = 0000, 1000, 2000, 4000. Left = 16'hC000 at volume 1 → F000. A volume change between captures does not alter the held word.
- **Reset and freeze.** Assert `reset` while `clk_audio` = 1. Required:
  - next cycle `clk_audio` = 0, `sample_word` = 0, `sample_stb` = 0;
  - after release, first toggle at cycle ⌈F/96000⌉.
  
  Then set `clk_freq` = 0. Required: `clk_audio` and `acc` hold for 1000 cycles with no strobe.
